m_store_buffer: RTL and testbench
=================================

M_STORE_BUFFER -- requirements
Module: m_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered stores (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset: synchronous, active-high.
REQ-004 SHALL have port st_valid  input  1  M-stage store request.
REQ-005 SHALL have port st_addr  input  32  store byte address.
REQ-006 SHALL have port st_data  input  32  store data, already lane-aligned.
REQ-007 SHALL have port st_be  input  4  store byte enables.
REQ-008 SHALL have port st_pc  input  32  PC of the store instruction.
REQ-009 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-010 SHALL have port ld_valid  input  1  M-stage load using the data-memory port.
REQ-011 SHALL have port ld_addr  input  32  load byte address.
REQ-012 SHALL have port ld_stall  output  1  load must hold in M (address conflict).
REQ-013 SHALL have ports dm_we (1), dm_addr (32), dm_wdata (32), dm_be (4), dm_pc (32)  output  drain write toward data memory.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL hold entries {addr, data, be, pc} in a circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-016 SHALL drive st_ready = (count != DEPTH), combinationally.
REQ-017 SHALL push the store at posedge when st_valid && st_ready; st_valid while full is ignored (upstream stalls).
REQ-018 SHALL make a pushed entry visible no earlier than the next cycle (store accepted cycle N -> earliest dm_we cycle N+1).
REQ-019 SHALL drive dm_addr/dm_wdata/dm_be/dm_pc from the head entry combinationally.
REQ-020 SHALL assert dm_we = (count != 0) && (!ld_valid || ld_stall) && !reset; a non-stalled load owns the memory port.
REQ-021 SHALL pop the head at posedge whenever dm_we is high (memory accepts one write per cycle, no back-pressure).
REQ-022 SHALL keep count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-023 SHALL drive ld_stall = ld_valid && (some valid entry has addr[31:2] == ld_addr[31:2]), ignoring byte enables; no data forwarding.
REQ-024 SHALL, when st_valid and ld_valid are both high, accept the store (if st_ready) and assert ld_stall.
REQ-025 SHALL drain in strict program order; entries to the same word are never merged or reordered.
REQ-026 SHALL guarantee progress: a stalled load never blocks draining, so the conflict clears within count cycles.
REQ-027 SHALL treat st_addr low bits as don't-care for matching; dm_addr carries the full stored st_addr.

Reset
REQ-028 SHALL, when reset is high at posedge, clear head, tail and count to 0 and discard all entries without writing them.
REQ-029 SHALL force dm_we = 0 during any cycle reset is high, regardless of count.
REQ-030 SHALL show after reset: count=0, st_ready=1, dm_we=0, ld_stall=0 (for any ld_addr).
REQ-031 SHALL ignore st_valid in a reset cycle (no push).

Verification
REQ-032 Single store: st_valid, addr 0x0000_0010, data 0xDEAD_BEEF, be 4'hF, pc 0x3000, no load -> next cycle dm_we=1 with those values, then count=0.
REQ-033 Fill/full: load held high without conflict, 4 stores to 0x0,0x4,0x8,0xC -> count=4, st_ready=0, 5th store ignored; drop ld_valid -> drains 0x0,0x4,0x8,0xC on 4 consecutive cycles.
REQ-034 Conflict: buffered store to 0x0000_0104, load ld_addr 0x0000_0106 -> ld_stall=1, dm_we=1 same cycle; next cycle ld_stall=0.
REQ-035 No conflict: buffered store to 0x100, load 0x200 -> ld_stall=0, dm_we=0 until load deasserts.
REQ-036 Wrap/simultaneous: steady push+pop for 10 cycles -> count constant at 1, pointers wrap, drained addresses in issue order.
REQ-037 Reset mid-operation: count=3, assert reset one cycle -> no dm_we that cycle or after, count=0, st_ready=1.

Source files
------------

// File: rtl/m_store_buffer.sv
// Store buffer between the M stage and the data-memory port.
// Stores are queued in a circular FIFO and drained in program order, one per cycle,
// whenever the memory port is not claimed by a load. A load that hits a buffered
// word (same 32-bit word address) is stalled until that entry has drained; no data
// is forwarded.
module m_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [3:0]                 st_be,
  input  logic [31:0]                st_pc,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_stall,
  output logic                       dm_we,
  output logic [31:0]                dm_addr,
  output logic [31:0]                dm_wdata,
  output logic [3:0]                 dm_be,
  output logic [31:0]                dm_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] match;
  logic             push, pop;

  // Byte offset of the load is irrelevant: conflicts are detected per word.
  logic unused_ld_low;
  assign unused_ld_low = ^ld_addr[1:0];

  // Handshake, conflict detection and drain control.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2]);
    end
    st_ready = (count_q != Full);
    ld_stall = ld_valid && (|match);
    // A stalled load yields the port so its conflicting entry can drain.
    dm_we    = (count_q != '0) && (!ld_valid || ld_stall) && !reset;
    push     = st_valid && st_ready && !reset;
    pop      = dm_we;
  end

  assign dm_addr  = addr_q[head_q];
  assign dm_wdata = data_q[head_q];
  assign dm_be    = be_q[head_q];
  assign dm_pc    = pc_q[head_q];
  assign count    = count_q;

  // Next-state for pointers, occupancy and per-entry valid bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all entries without draining them.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; contents are only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      be_q[tail_q]   <= st_be;
      pc_q[tail_q]   <= st_pc;
    end
  end

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer: inputs change at negedge, outputs are checked
// 1ns later, so every check sees the state left by the preceding posedge.
module tb_m_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data, st_pc;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_pc;
  logic [3:0]  dm_be;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  m_store_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .st_pc    (st_pc),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_stall (ld_stall),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_pc    (dm_pc),
    .count    (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one full cycle: one posedge, landing on the next negedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = 4'hF;
    st_pc    = pc;
  endtask

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_be    = '0;
    st_pc    = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    step();

    // Store offered during reset must be dropped.
    store(32'h0000_0040, 32'h1111_1111, 32'h100);
    #1 check("rst_dm_we", dm_we, 0);
    step();
    reset    = 1'b0;
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0040;
    #1;
    check("rst_count", count, 0);
    check("rst_st_ready", st_ready, 1);
    check("rst_dm_we2", dm_we, 0);
    check("rst_ld_stall", ld_stall, 0);
    ld_valid = 1'b0;
    step();

    // Single store: visible the cycle after acceptance.
    store(32'h0000_0010, 32'hDEAD_BEEF, 32'h3000);
    #1 check("single_same_cycle_we", dm_we, 0);
    step();
    st_valid = 1'b0;
    #1;
    check("single_dm_we", dm_we, 1);
    check("single_dm_addr", dm_addr, 32'h0000_0010);
    check("single_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
    check("single_dm_be", dm_be, 4'hF);
    check("single_dm_pc", dm_pc, 32'h3000);
    check("single_count1", count, 1);
    step();
    #1 check("single_count0", count, 0);

    // Fill while a non-conflicting load holds the port.
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      store(32'(4 * i), 32'hA000_0000 + 32'(i), 32'h4000 + 32'(4 * i));
      #1 check("fill_no_drain", dm_we, 0);
      step();
    end
    #1;
    check("full_count", count, 4);
    check("full_st_ready", st_ready, 0);
    store(32'h0000_0010, 32'hBAD0_BAD0, 32'h4010);
    step();
    #1 check("full_ignored_count", count, 4);
    st_valid = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_we", dm_we, 1);
      check("drain_addr", dm_addr, 32'(4 * i));
      check("drain_data", dm_wdata, 32'hA000_0000 + 32'(i));
      step();
    end
    #1 check("drain_empty", count, 0);

    // Conflict: same word, different byte offset.
    store(32'h0000_0104, 32'h0102_0304, 32'h5000);
    step();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0106;
    #1;
    check("conf_ld_stall", ld_stall, 1);
    check("conf_dm_we", dm_we, 1);
    check("conf_dm_addr", dm_addr, 32'h0000_0104);
    step();
    #1;
    check("conf_cleared", ld_stall, 0);
    check("conf_count", count, 0);
    ld_valid = 1'b0;

    // No conflict: load owns the port until it goes away.
    store(32'h0000_0100, 32'h5555_AAAA, 32'h6000);
    step();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0200;
    #1;
    check("noconf_ld_stall", ld_stall, 0);
    check("noconf_dm_we", dm_we, 0);
    step();
    #1;
    check("noconf_dm_we2", dm_we, 0);
    check("noconf_count", count, 1);
    ld_valid = 1'b0;
    #1;
    check("noconf_release_we", dm_we, 1);
    check("noconf_release_addr", dm_addr, 32'h0000_0100);
    step();
    #1 check("noconf_empty", count, 0);

    // Steady push+pop; 11 pushes wrap the depth-4 pointers.
    store(32'h0000_2000, 32'h0, 32'h7000);
    step();
    for (int k = 1; k <= 10; k++) begin
      store(32'h0000_2000 + 32'(4 * k), 32'(k), 32'h7000 + 32'(4 * k));
      #1;
      check("wrap_count", count, 1);
      check("wrap_we", dm_we, 1);
      check("wrap_addr", dm_addr, 32'h0000_2000 + 32'(4 * (k - 1)));
      step();
    end
    st_valid = 1'b0;
    #1 check("wrap_last_addr", dm_addr, 32'h0000_2028);
    step();
    #1 check("wrap_empty", count, 0);

    // Reset with three entries pending.
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      store(32'h0000_3000 + 32'(4 * i), 32'(i), 32'h8000);
      step();
    end
    st_valid = 1'b0;
    #1 check("pre_rst_count", count, 3);
    ld_valid = 1'b0;
    reset    = 1'b1;
    #1 check("midrst_dm_we", dm_we, 0);
    step();
    reset = 1'b0;
    #1;
    check("postrst_count", count, 0);
    check("postrst_st_ready", st_ready, 1);
    check("postrst_dm_we", dm_we, 0);
    step();
    #1 check("postrst_dm_we2", dm_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
